// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// Architectural register file for the single-cycle RISC-V core.
// It holds 2^AW registers of DW bits. It has two combinational read ports that
// feed the ALU operands and one synchronous write port for writeback.
// After every reset a sequencer zeroes x1..x31, one register per edge. While
// that runs, busy_o is high, reads return 0 and writes are dropped.
// A registered copy of x10 (a0) is exported for board-level observation.
//
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle write to
// any read port addressing the same register. Without it, a read in the same
// cycle as a write returns the stored (old) value.
//
// Ports:
//   clk_i   - system clock, rising edge
//   rst_i   - synchronous active-high reset
//   AD1_i   - read address, port 1 (rs1)
//   AD2_i   - read address, port 2 (rs2)
//   AD3_i   - write address (rd)
//   WE3_i   - write enable
//   WD3_i   - write data (ALU result)
//   RD1_o   - read data, port 1
//   RD2_o   - read data, port 2
//   a0_o    - registered copy of x10
//   busy_o  - high while the clear sequence runs (and during reset)
// -----------------------------------------------------------------------------
module reg_file #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] AD1_i,
  input  logic [AW-1:0] AD2_i,
  input  logic [AW-1:0] AD3_i,
  input  logic          WE3_i,
  input  logic [DW-1:0] WD3_i,
  output logic [DW-1:0] RD1_o,
  output logic [DW-1:0] RD2_o,
  output logic [DW-1:0] a0_o,
  output logic          busy_o
);

  localparam int NREG = 1 << AW;
  localparam logic [AW-1:0] LAST_PTR = AW'(NREG - 1);
  localparam logic [AW-1:0] FIRST_PTR = AW'(1);
  localparam logic [AW-1:0] A0_ADDR = AW'(10);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] a0_q, a0_d;

  logic [DW-1:0] mem_q [NREG];

  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memData;

  // Next state, clear pointer, a0 shadow and the single array write port.
  // The clear sequencer and the writeback path share one write port. They are
  // never active together because writeback is only accepted in READY.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    a0_d    = a0_q;
    memWe   = 1'b0;
    memAddr = '0;
    memData = '0;
    if (rst_i) begin
      state_d = CLEAR;
      ptr_d   = FIRST_PTR;
      a0_d    = '0;
    end else begin
      unique case (state_q)
        CLEAR: begin
          memWe   = 1'b1;
          memAddr = ptr_q;
          memData = '0;
          ptr_d   = ptr_q + 1'b1;
          if (ptr_q == LAST_PTR) begin
            state_d = READY;
          end
        end
        READY: begin
          if (WE3_i && (AD3_i != '0)) begin
            memWe   = 1'b1;
            memAddr = AD3_i;
            memData = WD3_i;
            if (AD3_i == A0_ADDR) begin
              a0_d = WD3_i;
            end
          end
        end
        default: begin
          state_d = CLEAR;
          ptr_d   = FIRST_PTR;
        end
      endcase
    end
  end

  // State, pointer and a0 registers. Reset is folded into the _d logic above,
  // so this block only captures the next-state values.
  always_ff @(posedge clk_i) begin
    state_q <= state_d;
    ptr_q   <= ptr_d;
    a0_q    <= a0_d;
  end

  // The register array itself is not reset. The clear sequencer zeroes it
  // after reset, which lets the array map onto plain storage.
  always_ff @(posedge clk_i) begin
    if (memWe) begin
      mem_q[memAddr] <= memData;
    end
  end

  // Combinational reads. Address 0 is hardwired to zero, and both ports are
  // held at zero until the clear sequence completes.
  always_comb begin
    RD1_o = '0;
    RD2_o = '0;
    if (state_q == READY) begin
      if (AD1_i != '0) begin
        RD1_o = mem_q[AD1_i];
      end
      if (AD2_i != '0) begin
        RD2_o = mem_q[AD2_i];
      end
`ifdef REGFILE_BYPASS_EN
      if (WE3_i && (AD3_i != '0) && (AD3_i == AD1_i)) begin
        RD1_o = WD3_i;
      end
      if (WE3_i && (AD3_i != '0) && (AD3_i == AD2_i)) begin
        RD2_o = WD3_i;
      end
`endif
    end
  end

  assign busy_o = (state_q == CLEAR);
  assign a0_o   = a0_q;

endmodule

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file
// Directed testbench for reg_file with a scoreboard.
// The driver applies one input vector per cycle, shortly after the rising edge.
// Along with each vector it queues the hand-computed outputs expected during
// that cycle. A separate monitor pops those entries on the falling edge and
// compares them against the DUT.
// -----------------------------------------------------------------------------
module tb_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // mask bits: 0 = RD1, 1 = RD2, 2 = a0, 3 = busy
  localparam logic [3:0] M_RD   = 4'b0011;
  localparam logic [3:0] M_RD1  = 4'b0001;
  localparam logic [3:0] M_A0   = 4'b0100;
  localparam logic [3:0] M_BUSY = 4'b1000;
  localparam logic [3:0] M_ALL  = 4'b1111;

  typedef struct {
    int          cyc;
    string       name;
    logic [3:0]  mask;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] a0;
    logic        busy;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] ad1 = '0;
  logic [AW-1:0] ad2 = '0;
  logic [AW-1:0] ad3 = '0;
  logic          we  = 1'b0;
  logic [DW-1:0] wd3 = '0;
  logic [DW-1:0] rd1, rd2, a0;
  logic          busy;

  int   cyc        = 0;
  int   testsRun   = 0;
  int   testsFailed = 0;
  exp_t sbQ[$];

  reg_file #(.DW(DW), .AW(AW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .AD1_i (ad1),
    .AD2_i (ad2),
    .AD3_i (ad3),
    .WE3_i (we),
    .WD3_i (wd3),
    .RD1_o (rd1),
    .RD2_o (rd2),
    .a0_o  (a0),
    .busy_o(busy)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Cycle index used to match scoreboard entries to the cycle they describe
  always @(posedge clk) cyc <= cyc + 1;

  // Wait for the next rising edge, then drive one input vector for this cycle
  task automatic applyStimulus(input logic r, input logic w,
                               input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                               input logic [AW-1:0] a3, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    rst = r;
    we  = w;
    ad1 = a1;
    ad2 = a2;
    ad3 = a3;
    wd3 = d;
  endtask

  // Queue the outputs expected during the current cycle
  task automatic expectOut(input string n, input logic [3:0] m,
                           input logic [31:0] e1, input logic [31:0] e2,
                           input logic [31:0] ea0, input logic eb);
    exp_t e;
    e.cyc  = cyc;
    e.name = n;
    e.mask = m;
    e.rd1  = e1;
    e.rd2  = e2;
    e.a0   = ea0;
    e.busy = eb;
    sbQ.push_back(e);
  endtask

  // Compare one scoreboard entry against what the DUT presents right now
  task automatic checkOutput(input exp_t e);
    if (e.cyc != cyc) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: checked in cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
    end
    if (e.mask[0]) begin
      testsRun++;
      if (rd1 !== e.rd1) begin
        testsFailed++;
        $display("[TB] FAIL %s RD1: got %h expected %h", e.name, rd1, e.rd1);
      end
    end
    if (e.mask[1]) begin
      testsRun++;
      if (rd2 !== e.rd2) begin
        testsFailed++;
        $display("[TB] FAIL %s RD2: got %h expected %h", e.name, rd2, e.rd2);
      end
    end
    if (e.mask[2]) begin
      testsRun++;
      if (a0 !== e.a0) begin
        testsFailed++;
        $display("[TB] FAIL %s a0: got %h expected %h", e.name, a0, e.a0);
      end
    end
    if (e.mask[3]) begin
      testsRun++;
      if (busy !== e.busy) begin
        testsFailed++;
        $display("[TB] FAIL %s busy: got %b expected %b", e.name, busy, e.busy);
      end
    end
  endtask

  // Monitor: on each falling edge, check every entry queued for this cycle
  always @(negedge clk) begin
    while (sbQ.size() > 0 && sbQ[0].cyc <= cyc) begin
      checkOutput(sbQ.pop_front());
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held for two edges
    applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    expectOut("reset1", M_ALL, 32'h0, 32'h0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    expectOut("reset2", M_ALL, 32'h0, 32'h0, 32'h0, 1'b1);

    // Release: busy is high for exactly 31 edges, and reads stay at zero
    applyStimulus(1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0);
    expectOut("clear0", M_ALL, 32'h0, 32'h0, 32'h0, 1'b1);
    for (int i = 1; i <= 31; i++) begin
      applyStimulus(1'b0, 1'b0, 5'(i), 5'(31 - i), 5'd0, 32'h0);
      expectOut((i == 31) ? "clearEnd" : "clearRun", M_ALL, 32'h0, 32'h0, 32'h0,
                (i < 31) ? 1'b1 : 1'b0);
    end

    // All registers read zero once ready
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, 5'(2 * i), 5'(2 * i + 1), 5'd0, 32'h0);
      expectOut("zeroScan", M_RD, 32'h0, 32'h0, 32'h0, 1'b0);
    end

    // Write x5 and read it back next cycle
    applyStimulus(1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 32'hDEADBEEF);
    expectOut("x5Same", M_RD, BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h0);
    expectOut("x5Read", M_ALL, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0);

    // A write to x0 is dropped, including its forwarding
    applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h12345678);
    expectOut("x0Same", M_RD, 32'h0, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 32'h0);
    expectOut("x0Read", M_RD, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    expectOut("x0Read2", M_RD1, 32'h0, 32'h0, 32'h0, 1'b0);

    // The a0 shadow updates on an x10 write and holds on other writes
    applyStimulus(1'b0, 1'b1, 5'd10, 5'd0, 5'd10, 32'h00000042);
    expectOut("a0Before", M_A0, 32'h0, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 5'd10, 5'd11, 5'd11, 32'h00000007);
    expectOut("a0After", M_ALL, 32'h42, BYP ? 32'h7 : 32'h0, 32'h42, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd10, 5'd11, 5'd0, 32'h0);
    expectOut("a0Hold", M_ALL, 32'h42, 32'h7, 32'h42, 1'b0);

    // Same-cycle read/write of x7, with a nonzero prior value
    applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'h11111111);
    applyStimulus(1'b0, 1'b1, 5'd7, 5'd7, 5'd7, 32'hA5A5A5A5);
    expectOut("x7Same", M_RD, BYP ? 32'hA5A5A5A5 : 32'h11111111,
              BYP ? 32'hA5A5A5A5 : 32'h11111111, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd7, 5'd10, 5'd0, 32'h0);
    expectOut("x7Next", M_ALL, 32'hA5A5A5A5, 32'h42, 32'h42, 1'b0);

    // Reset from READY, then re-assert reset after 10 clear edges
    applyStimulus(1'b1, 1'b0, 5'd5, 5'd10, 5'd0, 32'h0);
    applyStimulus(1'b0, 1'b0, 5'd5, 5'd10, 5'd0, 32'h0);
    expectOut("rstReady", M_ALL, 32'h0, 32'h0, 32'h0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b0, 1'b0, 5'd5, 5'd10, 5'd0, 32'h0);
      expectOut("partClear", M_ALL, 32'h0, 32'h0, 32'h0, 1'b1);
    end
    applyStimulus(1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 32'h0);
    expectOut("rstMid", M_BUSY, 32'h0, 32'h0, 32'h0, 1'b1);

    // Restarted sequence: 31 full edges of busy, with an x3 write held the whole time
    applyStimulus(1'b0, 1'b1, 5'd3, 5'd3, 5'd3, 32'h9);
    expectOut("restart0", M_ALL, 32'h0, 32'h0, 32'h0, 1'b1);
    for (int i = 1; i <= 31; i++) begin
      applyStimulus(1'b0, (i < 31) ? 1'b1 : 1'b0, 5'd3, 5'd5, 5'd3, 32'h9);
      expectOut((i == 31) ? "restartEnd" : "restartRun", M_ALL, 32'h0, 32'h0, 32'h0,
                (i < 31) ? 1'b1 : 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 5'd3, 5'd7, 5'd0, 32'h0);
    expectOut("x3Dropped", M_ALL, 32'h0, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd10, 5'd31, 5'd0, 32'h0);
    expectOut("postClear", M_RD, 32'h0, 32'h0, 32'h0, 1'b0);

    // Let the monitor drain the last entries
    @(posedge clk);
    @(negedge clk);
    #1;
    if (sbQ.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain: %0d entries left unchecked, required 0", sbQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
